output_port_alloc: RTL and testbench

Output-port allocator and flit multiplexer for one router output. It sits between the per-input buffers and one output link. It arbitrates among head flits with the round-robin `matrix_arb`, then locks the winner (wormhole) until its tail flit passes. It forwards flits through a single registered valid/ready stage.

---
 rtl/noc_flit_pkg.sv | 29 ++
 rtl/output_port_alloc_if.sv | 36 +++
 rtl/matrix_arb.sv | 54 +++++
 rtl/output_port_alloc.sv | 120 ++++++++++++
 tb/tb_output_port_alloc.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_flit_pkg.sv
`default_nettype none
// ============================================================================
// noc_flit_pkg
// Shared flit-format constants and router output-port FSM encoding.
// Revision: 1.0 - initial release
// ============================================================================
package noc_flit_pkg;

    // Width of the flit type field that occupies the top bits of every flit
    localparam int FLIT_TYPE_W = 2;

    // Bit offsets measured downward from the flit MSB
    localparam int HEAD_BIT = 0;
    localparam int TAIL_BIT = 1;

    // Flit type encodings {head, tail}
    localparam logic [FLIT_TYPE_W-1:0] FLIT_HEAD   = 2'b10;
    localparam logic [FLIT_TYPE_W-1:0] FLIT_BODY   = 2'b00;
    localparam logic [FLIT_TYPE_W-1:0] FLIT_TAIL   = 2'b01;
    localparam logic [FLIT_TYPE_W-1:0] FLIT_SINGLE = 2'b11;

    // Output-port ownership state
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/output_port_alloc_if.sv
`default_nettype none
// ============================================================================
// output_port_alloc_if
// Bundle of input-side flit handshakes, output link handshake and status
// for one router output port.
// Revision: 1.0 - initial release
// ============================================================================
interface output_port_alloc_if #(
    parameter int IN_N   = 5,
    parameter int FLIT_W = 10
);
    localparam int OWN_W = (IN_N > 1) ? $clog2(IN_N) : 1;

    logic [IN_N-1:0]        in_valid_i;
    logic [IN_N*FLIT_W-1:0] in_flit_i;
    logic [IN_N-1:0]        in_ready_o;
    logic                   out_valid_o;
    logic [FLIT_W-1:0]      out_flit_o;
    logic                   out_ready_i;
    logic                   busy_o;
    logic [OWN_W-1:0]       owner_o;

    // Upstream buffers and downstream link side
    modport master (
        output in_valid_i, in_flit_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_flit_o, busy_o, owner_o
    );

    // Allocator side
    modport slave (
        input  in_valid_i, in_flit_i, out_ready_i,
        output in_ready_o, out_valid_o, out_flit_o, busy_o, owner_o
    );

endinterface
`default_nettype wire

// File: rtl/matrix_arb.sv
`default_nettype none
// ============================================================================
// matrix_arb
// Round-robin matrix arbiter. prio[i][j] set means requester i beats j.
// The winner drops below every other requester after each grant, giving
// least-recently-granted fairness.
// Revision: 1.0 - initial release
// ============================================================================
module matrix_arb #(
    parameter int IN_N = 5
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [IN_N-1:0] req_i,
    output logic [IN_N-1:0] grant_o
);

    logic [IN_N-1:0][IN_N-1:0] r_prio;

    // A requester wins when no other active requester holds priority over it
    always_comb begin
        grant_o = '0;
        for (int i = 0; i < IN_N; i++) begin
            grant_o[i] = req_i[i];
            for (int j = 0; j < IN_N; j++) begin
                if ((j != i) && req_i[j] && r_prio[j][i]) begin
                    grant_o[i] = 1'b0;
                end
            end
        end
    end

    // Priority matrix: lowest index highest after reset; winner moves to last
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < IN_N; i++) begin
                for (int j = 0; j < IN_N; j++) begin
                    r_prio[i][j] <= (i < j);
                end
            end
        end else if (|grant_o) begin
            for (int i = 0; i < IN_N; i++) begin
                for (int j = 0; j < IN_N; j++) begin
                    if (grant_o[i] && (i != j)) begin
                        r_prio[i][j] <= 1'b0;
                        r_prio[j][i] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/output_port_alloc.sv
`default_nettype none
// ============================================================================
// output_port_alloc
// Wormhole output-port allocator and flit multiplexer. Head flits compete
// through a matrix arbiter; the winner owns the port until its tail flit
// passes. Flits leave through one registered valid/ready stage.
// Revision: 1.0 - initial release
// ============================================================================
module output_port_alloc
    import noc_flit_pkg::*;
#(
    parameter int IN_N   = 5,
    parameter int FLIT_W = 10
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    output_port_alloc_if.slave bus
);

    localparam int OWN_W    = (IN_N > 1) ? $clog2(IN_N) : 1;
    localparam int HEAD_IDX = FLIT_W - 1 - HEAD_BIT;
    localparam int TAIL_IDX = FLIT_W - 1 - TAIL_BIT;

    state_t                    r_state;
    logic [OWN_W-1:0]          r_owner;
    logic                      r_out_valid;
    logic [FLIT_W-1:0]         r_out_flit;

    logic [IN_N-1:0][FLIT_W-1:0] w_flits;
    logic [IN_N-1:0]           w_req;
    logic [IN_N-1:0]           w_grant;
    logic [OWN_W-1:0]          w_grant_idx;
    logic [FLIT_W-1:0]         w_own_flit;
    logic                      w_out_free;
    logic                      w_xfer;

    assign w_flits = bus.in_flit_i;

    // Only head flits compete, and only while the port is free, so the
    // arbiter priority advances exactly on a locking edge
    always_comb begin
        w_req = '0;
        for (int k = 0; k < IN_N; k++) begin
            w_req[k] = (r_state == ST_IDLE) && bus.in_valid_i[k] && w_flits[k][HEAD_IDX];
        end
    end

    matrix_arb #(
        .IN_N (IN_N)
    ) u_arb (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req_i   (w_req),
        .grant_o (w_grant)
    );

    // One-hot grant to owner index
    always_comb begin
        w_grant_idx = '0;
        for (int k = 0; k < IN_N; k++) begin
            if (w_grant[k]) begin
                w_grant_idx = OWN_W'(k);
            end
        end
    end

    // Flit mux follows the locked owner
    assign w_own_flit = w_flits[r_owner];

    // Output stage can take a flit when empty or draining this cycle
    assign w_out_free = ~r_out_valid | bus.out_ready_i;
    assign w_xfer     = (r_state == ST_LOCKED) && bus.in_valid_i[r_owner] && w_out_free;

    // Only the owner is ever offered ready; combinational for zero-bubble stalls
    always_comb begin
        bus.in_ready_o = '0;
        if ((r_state == ST_LOCKED) && w_out_free) begin
            bus.in_ready_o[r_owner] = 1'b1;
        end
    end

    // Lock/unlock FSM together with the registered output stage
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_owner     <= '0;
            r_out_valid <= 1'b0;
            r_out_flit  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_req) begin
                        r_owner <= w_grant_idx;
                        r_state <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (w_xfer && w_own_flit[TAIL_IDX]) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_flit  <= w_own_flit;
            end else if (bus.out_ready_i) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid_o = r_out_valid;
    assign bus.out_flit_o  = r_out_flit;
    assign bus.busy_o      = (r_state == ST_LOCKED);
    assign bus.owner_o     = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_output_port_alloc.sv
`default_nettype none
// ============================================================================
// tb_output_port_alloc
// Self-checking bench for the wormhole output-port allocator: directed
// scenarios plus randomized traffic against a packet-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_output_port_alloc;
    import noc_flit_pkg::*;

    localparam int IN_N   = 5;
    localparam int FLIT_W = 10;
    localparam int OWN_W  = 3;
    localparam int PAY_W  = FLIT_W - FLIT_TYPE_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    output_port_alloc_if #(.IN_N(IN_N), .FLIT_W(FLIT_W)) bus ();

    output_port_alloc #(.IN_N(IN_N), .FLIT_W(FLIT_W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [FLIT_W-1:0] src_q [IN_N][$];
    logic [FLIT_W-1:0] exp_q [$];
    logic [FLIT_W-1:0] out_log [$];
    int                out_cyc [$];
    int                own_seq [$];
    logic [IN_N-1:0]   gate    = '1;
    logic              out_rdy = 1'b1;
    int                cyc     = 0;

    function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t, input int p);
        logic [31:0] pv;
        pv = p;
        return {t, pv[PAY_W-1:0]};
    endfunction

    function automatic bit logs_match();
        if (out_log.size() != exp_q.size()) return 1'b0;
        foreach (exp_q[i]) if (out_log[i] !== exp_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive();
        logic [IN_N-1:0]             v;
        logic [IN_N-1:0][FLIT_W-1:0] f;
        v = '0;
        f = '0;
        for (int k = 0; k < IN_N; k++) begin
            if (src_q[k].size() > 0) begin
                v[k] = gate[k];
                f[k] = src_q[k][0];
            end
        end
        bus.in_valid_i  = v;
        bus.in_flit_i   = f;
        bus.out_ready_i = out_rdy;
    endtask

    // Advance one clock; called at the mid-cycle sample point
    task automatic cycle();
        logic [IN_N-1:0] acc;
        acc = bus.in_ready_o & bus.in_valid_i;
        if (bus.out_valid_o && bus.out_ready_i) begin
            out_log.push_back(bus.out_flit_o);
            out_cyc.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        for (int k = 0; k < IN_N; k++) if (acc[k]) void'(src_q[k].pop_front());
        #1;
        drive();
        #1;
    endtask

    task automatic clear_logs();
        exp_q.delete();
        out_log.delete();
        out_cyc.delete();
        own_seq.delete();
        cyc = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int k = 0; k < IN_N; k++) src_q[k].delete();
        gate    = '1;
        out_rdy = 1'b1;
        drive();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive();
        #1;
        clear_logs();
    endtask

    task automatic push_pkt(input int k, input int len, input int base);
        logic [FLIT_W-1:0] f;
        for (int i = 0; i < len; i++) begin
            if (len == 1)           f = mk(FLIT_SINGLE, base);
            else if (i == 0)        f = mk(FLIT_HEAD, base);
            else if (i == len - 1)  f = mk(FLIT_TAIL, base + i);
            else                    f = mk(FLIT_BODY, base + i);
            src_q[k].push_back(f);
            exp_q.push_back(f);
        end
    endtask

    task automatic run_until_drained(input int max_cyc, output bit timed_out);
        bit prev_busy;
        bit empty;
        drive();
        #1;
        prev_busy = bus.busy_o;
        timed_out = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            empty = 1'b1;
            for (int k = 0; k < IN_N; k++) if (src_q[k].size() != 0) empty = 1'b0;
            if (empty && !bus.out_valid_o && !bus.busy_o) begin
                timed_out = 1'b0;
                break;
            end
            cycle();
            if (bus.busy_o && !prev_busy) own_seq.push_back(int'(bus.owner_o));
            prev_busy = bus.busy_o;
        end
    endtask

    task automatic test_reset();
        src_q[0].push_back(mk(FLIT_HEAD, 1));
        drive();
        #12;
        n_tests++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid_o); end
        n_tests++; if (bus.out_flit_o !== '0) begin n_fail++; $display("FAIL rst_out_flit: got %h expected 000", bus.out_flit_o); end
        n_tests++; if (bus.in_ready_o !== '0) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 00000", bus.in_ready_o); end
        n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", bus.busy_o); end
        n_tests++; if (bus.owner_o !== '0) begin n_fail++; $display("FAIL rst_owner: got %0d expected 0", bus.owner_o); end
    endtask

    task automatic test_single_packet();
        logic [FLIT_W-1:0] h, b, t;
        apply_reset();
        h = mk(FLIT_HEAD, 8'h21); b = mk(FLIT_BODY, 8'h22); t = mk(FLIT_TAIL, 8'h23);
        src_q[2].push_back(h); src_q[2].push_back(b); src_q[2].push_back(t);
        drive(); #1;
        n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL sp_busy_c0: got %b expected 0", bus.busy_o); end
        cycle();
        n_tests++; if (bus.busy_o !== 1'b1 || bus.owner_o !== 3'd2) begin n_fail++; $display("FAIL sp_lock: got busy=%b owner=%0d expected busy=1 owner=2", bus.busy_o, bus.owner_o); end
        n_tests++; if (bus.in_ready_o !== 5'b00100) begin n_fail++; $display("FAIL sp_ready: got %b expected 00100", bus.in_ready_o); end
        n_tests++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL sp_no_out_c1: got %b expected 0", bus.out_valid_o); end
        cycle();
        n_tests++; if (bus.out_valid_o !== 1'b1 || bus.out_flit_o !== h) begin n_fail++; $display("FAIL sp_head: got v=%b %h expected v=1 %h", bus.out_valid_o, bus.out_flit_o, h); end
        cycle();
        n_tests++; if (bus.out_valid_o !== 1'b1 || bus.out_flit_o !== b) begin n_fail++; $display("FAIL sp_body: got v=%b %h expected v=1 %h", bus.out_valid_o, bus.out_flit_o, b); end
        n_tests++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL sp_busy_mid: got %b expected 1", bus.busy_o); end
        cycle();
        n_tests++; if (bus.out_valid_o !== 1'b1 || bus.out_flit_o !== t) begin n_fail++; $display("FAIL sp_tail: got v=%b %h expected v=1 %h", bus.out_valid_o, bus.out_flit_o, t); end
        n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL sp_unlock: got %b expected 0", bus.busy_o); end
        cycle();
        n_tests++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL sp_drain: got %b expected 0", bus.out_valid_o); end
    endtask

    task automatic test_alternate();
        bit to;
        int exp_own;
        clear_logs();
        for (int p = 0; p < 3; p++) begin
            push_pkt(0, 2, 8'h00 + 4 * p);
            push_pkt(1, 2, 8'h80 + 4 * p);
        end
        run_until_drained(100, to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL alt_timeout: got timeout=%b expected 0", to); end
        n_tests++; if (own_seq.size() != 6) begin n_fail++; $display("FAIL alt_nlocks: got %0d expected 6", own_seq.size()); end
        foreach (own_seq[i]) begin
            exp_own = i % 2;
            n_tests++; if (own_seq[i] != exp_own) begin n_fail++; $display("FAIL alt_owner[%0d]: got %0d expected %0d", i, own_seq[i], exp_own); end
        end
        n_tests++; if (logs_match() !== 1'b1) begin n_fail++; $display("FAIL alt_stream: got %0d flits expected %0d in order", out_log.size(), exp_q.size()); end
        for (int i = 1; i < out_cyc.size(); i++) begin
            n_tests++;
            if (out_cyc[i] - out_cyc[i-1] != ((i % 2 == 0) ? 2 : 1)) begin
                n_fail++; $display("FAIL alt_spacing[%0d]: got %0d expected %0d", i, out_cyc[i] - out_cyc[i-1], (i % 2 == 0) ? 2 : 1);
            end
        end
    endtask

    task automatic test_backpressure();
        bit to;
        logic [FLIT_W-1:0] held;
        clear_logs();
        push_pkt(3, 4, 8'h30);
        held = exp_q[0];
        drive(); #1;
        cycle();
        cycle();
        out_rdy = 1'b0;
        drive(); #1;
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (bus.out_valid_o !== 1'b1 || bus.out_flit_o !== held) begin n_fail++; $display("FAIL bp_hold[%0d]: got v=%b %h expected v=1 %h", i, bus.out_valid_o, bus.out_flit_o, held); end
            n_tests++; if (bus.in_ready_o !== '0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b expected 00000", i, bus.in_ready_o); end
            cycle();
        end
        out_rdy = 1'b1;
        run_until_drained(50, to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL bp_timeout: got timeout=%b expected 0", to); end
        n_tests++; if (logs_match() !== 1'b1) begin n_fail++; $display("FAIL bp_stream: got %0d flits expected %0d in order", out_log.size(), exp_q.size()); end
    endtask

    task automatic test_singles();
        bit to;
        int exp_own [3];
        apply_reset();
        exp_own = '{0, 3, 4};
        push_pkt(0, 1, 8'hA0);
        push_pkt(3, 1, 8'hA3);
        push_pkt(4, 1, 8'hA4);
        run_until_drained(50, to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL sg_timeout: got timeout=%b expected 0", to); end
        n_tests++; if (own_seq.size() != 3) begin n_fail++; $display("FAIL sg_nlocks: got %0d expected 3", own_seq.size()); end
        foreach (own_seq[i]) begin
            if (i < 3) begin
                n_tests++; if (own_seq[i] != exp_own[i]) begin n_fail++; $display("FAIL sg_owner[%0d]: got %0d expected %0d", i, own_seq[i], exp_own[i]); end
            end
        end
        n_tests++; if (logs_match() !== 1'b1) begin n_fail++; $display("FAIL sg_stream: got %0d flits expected %0d in order", out_log.size(), exp_q.size()); end
        for (int i = 1; i < out_cyc.size(); i++) begin
            n_tests++; if (out_cyc[i] - out_cyc[i-1] != 2) begin n_fail++; $display("FAIL sg_cost[%0d]: got %0d expected 2", i, out_cyc[i] - out_cyc[i-1]); end
        end
    endtask

    task automatic test_isolation();
        bit to;
        clear_logs();
        src_q[1].push_back(mk(FLIT_BODY, 8'h77));
        push_pkt(0, 4, 8'h40);
        drive(); #1;
        for (int i = 0; i < 12; i++) begin
            n_tests++; if (bus.in_ready_o[1] !== 1'b0) begin n_fail++; $display("FAIL iso_ready1[%0d]: got %b expected 0", i, bus.in_ready_o[1]); end
            cycle();
        end
        n_tests++; if (src_q[1].size() != 1) begin n_fail++; $display("FAIL iso_held: got %0d queued expected 1", src_q[1].size()); end
        n_tests++; if (logs_match() !== 1'b1) begin n_fail++; $display("FAIL iso_stream: got %0d flits expected %0d", out_log.size(), exp_q.size()); end
        n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL iso_idle: got busy=%b expected 0", bus.busy_o); end
        src_q[1].delete();
        push_pkt(1, 2, 8'h50);
        run_until_drained(50, to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL iso_timeout: got timeout=%b expected 0", to); end
        n_tests++; if (logs_match() !== 1'b1) begin n_fail++; $display("FAIL iso_head_fwd: got %0d flits expected %0d", out_log.size(), exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit to;
        clear_logs();
        push_pkt(1, 4, 8'h60);
        drive(); #1;
        cycle();
        cycle();
        n_tests++; if (bus.out_valid_o !== 1'b1 || bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL rm_pre: got v=%b busy=%b expected 1 1", bus.out_valid_o, bus.busy_o); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL rm_out_valid: got %b expected 0", bus.out_valid_o); end
        n_tests++; if (bus.out_flit_o !== '0) begin n_fail++; $display("FAIL rm_out_flit: got %h expected 000", bus.out_flit_o); end
        n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b expected 0", bus.busy_o); end
        n_tests++; if (bus.owner_o !== '0) begin n_fail++; $display("FAIL rm_owner: got %0d expected 0", bus.owner_o); end
        n_tests++; if (bus.in_ready_o !== '0) begin n_fail++; $display("FAIL rm_ready: got %b expected 00000", bus.in_ready_o); end
        apply_reset();
        push_pkt(3, 2, 8'h70);
        run_until_drained(50, to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL rm_timeout: got timeout=%b expected 0", to); end
        n_tests++; if (own_seq.size() != 1 || own_seq[0] != 3) begin n_fail++; $display("FAIL rm_regrant: got %0d locks expected one lock on input 3", own_seq.size()); end
        n_tests++; if (logs_match() !== 1'b1) begin n_fail++; $display("FAIL rm_stream: got %0d flits expected %0d", out_log.size(), exp_q.size()); end
    endtask

    // Reference: packet-level ownership with least-recently-granted order list
    task automatic test_random();
        int                          prio [$];
        bit                          m_locked, m_ov, fr, won;
        int                          m_own, c;
        logic [FLIT_W-1:0]           m_of;
        logic [IN_N-1:0]             v, er;
        logic [IN_N-1:0][FLIT_W-1:0] f;
        logic [1:0]                  ty;
        apply_reset();
        for (int k = 0; k < IN_N; k++) prio.push_back(k);
        m_locked = 0; m_ov = 0; m_own = 0; m_of = '0;
        for (int n = 0; n < 1500; n++) begin
            for (int k = 0; k < IN_N; k++) begin
                if (src_q[k].size() == 0 && $urandom_range(3) == 0)
                    push_pkt(k, int'($urandom_range(4, 1)), int'($urandom_range(255)));
                gate[k] = ($urandom_range(7) != 0);
            end
            out_rdy = ($urandom_range(3) != 0);
            drive();
            #1;
            fr = !m_ov || out_rdy;
            er = (m_locked && fr) ? (IN_N'(1) << m_own) : '0;
            n_tests++; if (bus.busy_o !== m_locked) begin n_fail++; $display("FAIL rnd_busy@%0d: got %b expected %b", n, bus.busy_o, m_locked); end
            if (m_locked) begin
                n_tests++; if (int'(bus.owner_o) != m_own) begin n_fail++; $display("FAIL rnd_owner@%0d: got %0d expected %0d", n, bus.owner_o, m_own); end
            end
            n_tests++; if (bus.in_ready_o !== er) begin n_fail++; $display("FAIL rnd_ready@%0d: got %b expected %b", n, bus.in_ready_o, er); end
            n_tests++; if (bus.out_valid_o !== m_ov) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b expected %b", n, bus.out_valid_o, m_ov); end
            if (m_ov) begin
                n_tests++; if (bus.out_flit_o !== m_of) begin n_fail++; $display("FAIL rnd_flit@%0d: got %h expected %h", n, bus.out_flit_o, m_of); end
            end
            v = bus.in_valid_i;
            f = bus.in_flit_i;
            if (m_locked) begin
                if (v[m_own] && fr) begin
                    m_ov = 1; m_of = f[m_own];
                    ty = m_of[FLIT_W-1 -: 2];
                    if (ty == FLIT_TAIL || ty == FLIT_SINGLE) m_locked = 0;
                end else if (out_rdy) begin
                    m_ov = 0;
                end
            end else begin
                if (out_rdy) m_ov = 0;
                won = 0;
                for (int i = 0; i < prio.size(); i++) begin
                    c  = prio[i];
                    ty = f[c][FLIT_W-1 -: 2];
                    if (!won && v[c] && (ty == FLIT_HEAD || ty == FLIT_SINGLE)) begin
                        won = 1; m_own = c; m_locked = 1;
                        prio.delete(i);
                        prio.push_back(c);
                        break;
                    end
                end
            end
            cycle();
        end
    endtask

    initial begin
        bus.in_valid_i  = '0;
        bus.in_flit_i   = '0;
        bus.out_ready_i = 1'b1;
        test_reset();
        test_single_packet();
        test_alternate();
        test_backpressure();
        test_singles();
        test_isolation();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d failed so far", n_fail);
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
